// File: rtl/axis_argmax_stage_if.sv
// Stream bundle around the argmax stage: element input side (s_axis_*) and result output side (m_axis_*).
// slave = the stage itself, master = the surrounding environment (upstream producer plus downstream consumer).
interface axis_argmax_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 8
);
  logic                  s_axis_valid;
  logic [DATA_WIDTH-1:0] s_axis_data;
  logic                  s_axis_ready;
  logic                  m_axis_valid;
  logic [IDX_WIDTH-1:0]  m_axis_index;
  logic [DATA_WIDTH-1:0] m_axis_max;
  logic                  m_axis_ready;

  modport slave (
    input  s_axis_valid, s_axis_data, m_axis_ready,
    output s_axis_ready, m_axis_valid, m_axis_index, m_axis_max
  );

  modport master (
    output s_axis_valid, s_axis_data, m_axis_ready,
    input  s_axis_ready, m_axis_valid, m_axis_index, m_axis_max
  );
endinterface

// File: rtl/axis_argmax_stage.sv
// Per-frame argmax over VEC_LEN signed elements; emits one (index, max) beat per frame
// and holds it, stalling the upstream, until the downstream takes it.
module axis_argmax_stage #(
  parameter int unsigned VEC_LEN    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset,
  axis_argmax_stage_if.slave   axis,
  output logic [CNT_WIDTH-1:0] frame_count
);

  localparam int unsigned EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [EW-1:0] LAST = EW'(VEC_LEN - 1);

  typedef enum logic {ACCUM, OUTPUT} state_t;

  state_t                state, state_next;
  logic [EW-1:0]         elem_cnt;
  logic [IDX_WIDTH-1:0]  best_idx, out_idx, cand_idx;
  logic [DATA_WIDTH-1:0] best_val, out_max, cand_val;
  logic                  rdy_q;
  logic                  accept, last, take, handoff;

  assign accept  = axis.s_axis_valid & rdy_q;
  assign last    = (elem_cnt == LAST);
  assign handoff = (state == OUTPUT) & axis.m_axis_ready;

  // Element 0 always seeds the running best; later ones win only on strictly greater.
  assign take     = (elem_cnt == '0) || ($signed(axis.s_axis_data) > $signed(best_val));
  assign cand_idx = take ? IDX_WIDTH'(elem_cnt) : best_idx;
  assign cand_val = take ? axis.s_axis_data : best_val;

  assign axis.s_axis_ready = rdy_q;
  assign axis.m_axis_valid = (state == OUTPUT);
  assign axis.m_axis_index = out_idx;
  assign axis.m_axis_max   = out_max;

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) state <= ACCUM;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM:  if (accept && last) state_next = OUTPUT;
      OUTPUT: if (axis.m_axis_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Ready is registered from the next state so it stays low through reset and
  // never depends combinationally on s_axis_valid.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) rdy_q <= 1'b0;
    else           rdy_q <= (state_next == ACCUM);
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      elem_cnt <= '0;
      best_idx <= '0;
      best_val <= '0;
      out_idx  <= '0;
      out_max  <= '0;
    end else if (accept) begin
      best_idx <= cand_idx;
      best_val <= cand_val;
      if (last) begin
        elem_cnt <= '0;
        out_idx  <= cand_idx;
        out_max  <= cand_val;
      end else begin
        elem_cnt <= elem_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset)                       frame_count <= '0;
    else if (handoff && frame_count != '1) frame_count <= frame_count + 1'b1;
  end

endmodule

// File: tb/tb_axis_argmax_stage.sv
// Bench for axis_argmax_stage: a VEC_LEN=4 instance and a VEC_LEN=1 instance (4-bit frame counter)
// checked every cycle against a queue-based argmax model.
module tb_axis_argmax_stage;

  typedef struct { int idx; int val; } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fc4;
  logic [3:0]  fc1;

  int total = 0, passed = 0, failed = 0;

  int   fr4[$], fr1[$];
  res_t exp4[$], exp1[$];
  int   fcm4 = 0, fcm1 = 0;

  axis_argmax_stage_if #(.DATA_WIDTH(32), .IDX_WIDTH(8)) bus4 ();
  axis_argmax_stage_if #(.DATA_WIDTH(32), .IDX_WIDTH(8)) bus1 ();

  axis_argmax_stage #(.VEC_LEN(4), .DATA_WIDTH(32), .IDX_WIDTH(8), .CNT_WIDTH(16)) u4 (
    .axi_clk(clk), .axi_reset(rst), .axis(bus4.slave), .frame_count(fc4)
  );
  axis_argmax_stage #(.VEC_LEN(1), .DATA_WIDTH(32), .IDX_WIDTH(8), .CNT_WIDTH(4)) u1 (
    .axi_clk(clk), .axi_reset(rst), .axis(bus1.slave), .frame_count(fc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t ref_argmax(input int q[$]);
    res_t r;
    int b = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i] > q[b]) b = i;
    r.idx = b;
    r.val = q[b];
    return r;
  endfunction

  function automatic int rnd_data();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 6)) - 3;
  endfunction

  // One clock: capture what transfers at the edge, advance the model, then check every output.
  task automatic step();
    bit a4, a1, h4, h1;
    int d4, d1;
    a4 = bus4.s_axis_valid && bus4.s_axis_ready;
    a1 = bus1.s_axis_valid && bus1.s_axis_ready;
    h4 = bus4.m_axis_valid && bus4.m_axis_ready;
    h1 = bus1.m_axis_valid && bus1.m_axis_ready;
    d4 = bus4.s_axis_data;
    d1 = bus1.s_axis_data;
    @(posedge clk);
    #1;
    if (h4) begin
      chk("out4_expected", exp4.size() != 0, 1);
      if (exp4.size() != 0) void'(exp4.pop_front());
      if (fcm4 < 65535) fcm4++;
    end
    if (h1) begin
      chk("out1_expected", exp1.size() != 0, 1);
      if (exp1.size() != 0) void'(exp1.pop_front());
      if (fcm1 < 15) fcm1++;
    end
    if (a4) begin
      fr4.push_back(d4);
      if (fr4.size() == 4) begin
        exp4.push_back(ref_argmax(fr4));
        fr4.delete();
      end
    end
    if (a1) begin
      fr1.push_back(d1);
      exp1.push_back(ref_argmax(fr1));
      fr1.delete();
    end
    chk("valid4", bus4.m_axis_valid, exp4.size() != 0);
    chk("ready4", bus4.s_axis_ready, exp4.size() == 0);
    chk("fc4", fc4, fcm4);
    if (exp4.size() != 0) begin
      chk("idx4", bus4.m_axis_index, exp4[0].idx);
      chk("max4", bus4.m_axis_max, $unsigned(exp4[0].val));
    end
    chk("valid1", bus1.m_axis_valid, exp1.size() != 0);
    chk("ready1", bus1.s_axis_ready, exp1.size() == 0);
    chk("fc1", fc1, fcm1);
    if (exp1.size() != 0) begin
      chk("idx1", bus1.m_axis_index, exp1[0].idx);
      chk("max1", bus1.m_axis_max, $unsigned(exp1[0].val));
    end
  endtask

  task automatic do_reset();
    bus4.s_axis_valid = 1'b0;
    bus1.s_axis_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid4", bus4.m_axis_valid, 0);
    chk("rst_ready4", bus4.s_axis_ready, 0);
    chk("rst_fc4", fc4, 0);
    chk("rst_valid1", bus1.m_axis_valid, 0);
    chk("rst_fc1", fc1, 0);
    fr4.delete(); fr1.delete(); exp4.delete(); exp1.delete();
    fcm4 = 0; fcm1 = 0;
    @(posedge clk);
    #1;
    chk("rst_idx4", bus4.m_axis_index, 0);
    chk("rst_max4", bus4.m_axis_max, 0);
    chk("rst_ready1", bus1.s_axis_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready4", bus4.s_axis_ready, 1);
    chk("post_rst_ready1", bus1.s_axis_ready, 1);
  endtask

  // Offer one element and wait (bounded) until it is taken; valid is left asserted.
  task automatic push4(input int v);
    bit acc = 0;
    int n = 0;
    bus4.s_axis_valid = 1'b1;
    bus4.s_axis_data  = v;
    while (!acc && n < 50) begin
      acc = bus4.s_axis_ready;
      step();
      n++;
    end
    chk("push4_accept", acc, 1);
  endtask

  task automatic push1(input int v);
    bit acc = 0;
    int n = 0;
    bus1.s_axis_valid = 1'b1;
    bus1.s_axis_data  = v;
    while (!acc && n < 50) begin
      acc = bus1.s_axis_ready;
      step();
      n++;
    end
    chk("push1_accept", acc, 1);
  endtask

  task automatic frame4(input int v[4]);
    for (int i = 0; i < 4; i++) push4(v[i]);
    bus4.s_axis_valid = 1'b0;
  endtask

  task automatic expect4(input int idx, input int val);
    chk("res4_valid", bus4.m_axis_valid, 1);
    chk("res4_idx", bus4.m_axis_index, idx);
    chk("res4_max", bus4.m_axis_max, $unsigned(val));
  endtask

  task automatic drain();
    int n = 0;
    bus4.s_axis_valid = 1'b0;
    bus1.s_axis_valid = 1'b0;
    bus4.m_axis_ready = 1'b1;
    bus1.m_axis_ready = 1'b1;
    while ((exp4.size() != 0 || exp1.size() != 0) && n < 20) begin
      step();
      n++;
    end
    chk("drain4", exp4.size(), 0);
    chk("drain1", exp1.size(), 0);
  endtask

  initial begin
    bus4.s_axis_valid = 1'b0; bus4.s_axis_data = '0; bus4.m_axis_ready = 1'b1;
    bus1.s_axis_valid = 1'b0; bus1.s_axis_data = '0; bus1.m_axis_ready = 1'b1;
    do_reset();

    // basic frame, valid held
    frame4('{5, -3, 9, 9});
    expect4(2, 9);
    drain();
    chk("fc4_first", fc4, 1);

    // signed compare with tie, then all most-negative
    frame4('{-7, -2, -9, -2});
    expect4(1, -2);
    drain();
    frame4('{int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000)});
    expect4(0, int'(32'h8000_0000));
    drain();

    // backpressure with upstream valid held through the stall
    bus4.m_axis_ready = 1'b0;
    for (int i = 0; i < 4; i++) push4(i == 2 ? 4 : (i == 1 ? -5 : (i == 0 ? 1 : 0)));
    bus4.s_axis_data = 100;
    for (int i = 0; i < 5; i++) begin
      expect4(2, 4);
      chk("bp_ready4", bus4.s_axis_ready, 0);
      step();
    end
    bus4.m_axis_ready = 1'b1;
    step();
    push4(100);
    push4(-1);
    push4(100);
    push4(7);
    bus4.s_axis_valid = 1'b0;
    expect4(0, 100);
    drain();

    // bubbles
    begin
      bit vs[7] = '{1, 0, 0, 1, 0, 1, 1};
      int ds[7] = '{3, 55, 66, 8, 77, 1, 2};
      for (int i = 0; i < 7; i++) begin
        bus4.s_axis_valid = vs[i];
        bus4.s_axis_data  = ds[i];
        step();
      end
      bus4.s_axis_valid = 1'b0;
      expect4(1, 8);
      drain();
    end

    // reset mid-frame
    push4(50);
    push4(60);
    do_reset();
    frame4('{1, 2, 3, 4});
    expect4(3, 4);
    drain();
    chk("fc4_after_rst", fc4, 1);

    // reset while a result is pending
    bus4.m_axis_ready = 1'b0;
    frame4('{9, 8, 7, 6});
    step();
    do_reset();
    bus4.m_axis_ready = 1'b1;

    // VEC_LEN=1 back-to-back
    push1(7);
    push1(-1);
    push1(0);
    bus1.s_axis_valid = 1'b0;
    drain();
    chk("fc1_three", fc1, 3);

    // randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      bus4.s_axis_valid = ($urandom_range(0, 2) != 0);
      bus4.s_axis_data  = rnd_data();
      bus4.m_axis_ready = ($urandom_range(0, 2) != 0);
      bus1.s_axis_valid = ($urandom_range(0, 2) != 0);
      bus1.s_axis_data  = rnd_data();
      bus1.m_axis_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    // frame counter saturation on the 4-bit instance
    bus1.m_axis_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus1.s_axis_valid = 1'b1;
      bus1.s_axis_data  = rnd_data();
      step();
    end
    drain();
    chk("fc1_saturated", fc1, 4'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
